// File: rtl/uart_pkg.sv
// Shared UART package: frame state encoding and default frame constants,
// reused by the transmitter and the future receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte through a valid/ready handshake and
// serialises it LSB-first on tx, one bit per baud_tick period.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned STOP_BITS  = UART_STOP_BITS,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 stop_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

`ifdef UART_TX_PARITY_EN
    localparam logic ODD_BIT = 1'(PARITY_ODD);
    // Running XOR of the bits already shifted out of the latched copy.
    logic par_q;
`else
    logic parity_odd_unused;
    assign parity_odd_unused = 1'(PARITY_ODD);
`endif

    // Next shift-register contents and bit count for a data-bit advance.
    always_comb begin
        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
    end

    // Frame sequencer with registered line, handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_valid && ready_q) begin
                        shift_q <= tx_data;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (baud_tick) begin
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
                        par_q   <= shift_q[0];
`endif
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (cnt_q != LAST_IDX) begin
                            cnt_q   <= cnt_d;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
                            par_q   <= par_q ^ shift_q[0];
`endif
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q ^ ODD_BIT;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            stop_q  <= 1'b0;
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        if (stop_q == LAST_STOP) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default 8N1 instance plus a 5-data/2-stop,
// odd-parity instance; baud_tick every 16 clk cycles.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] data1     = '0;
    logic       valid1    = 1'b0;
    logic       ready1, tx1, busy1, done1;
    logic [4:0] data2     = '0;
    logic       valid2    = 1'b0;
    logic       ready2, tx2, busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned phase = 0;

    uart_tx u_dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
        .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    uart_tx #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
        .tx(tx2), .tx_busy(busy2), .tx_done(done2)
    );

    always #5 clk = ~clk;

    // Free-running baud tick, one clk wide every 16 cycles, driven off the falling edge.
    always @(negedge clk) begin
        phase     = (phase + 1) % 16;
        baud_tick = (phase == 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic get_tx(input int which);
        return (which == 0) ? tx1 : tx2;
    endfunction
    function automatic logic get_ready(input int which);
        return (which == 0) ? ready1 : ready2;
    endfunction
    function automatic logic get_busy(input int which);
        return (which == 0) ? busy1 : busy2;
    endfunction
    function automatic logic get_done(input int which);
        return (which == 0) ? done1 : done2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; handshake happens on the next rising edge.
    task automatic send(input int which, input logic [7:0] data, input bit hold);
        if (which == 0) begin data1 = data; valid1 = 1'b1; end
        else begin data2 = data[4:0]; valid2 = 1'b1; end
        @(negedge clk);
        chk($sformatf("accept_ready%0d", which), 32'(get_ready(which)), 32'd0);
        chk($sformatf("accept_busy%0d", which), 32'(get_busy(which)), 32'd1);
        if (!hold) begin
            if (which == 0) valid1 = 1'b0; else valid2 = 1'b0;
        end
    endtask

    // Counts falling edges until tx goes low; 0 means the start bit never came.
    task automatic wait_start(input int which, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (get_tx(which) == 1'b0) begin
                lat = i;
                break;
            end
        end
        chk($sformatf("start_seen%0d", which), 32'(lat != 0), 32'd1);
    endtask

    // Starts on the first low sample of the start bit; ends on the tx_done sample.
    task automatic check_frame(input int which, input logic [7:0] data);
        int   nb;
        int   ns;
        logic p;
        logic bits[$];
        nb = (which == 0) ? 8 : 5;
        ns = (which == 0) ? 1 : 2;
        p  = (which == 0) ? 1'b0 : 1'b1;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(data[i]);
            p = p ^ data[i];
        end
        if (PAR_EN) bits.push_back(p);
        for (int i = 0; i < ns; i++) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("tx%0d d=%0h bit%0d cyc%0d", which, data, b, k),
                    32'(get_tx(which)), 32'(bits[b]));
                if (k == 0 || k == 15) begin
                    chk($sformatf("ready_low%0d bit%0d", which, b), 32'(get_ready(which)), 32'd0);
                    chk($sformatf("done_low%0d bit%0d", which, b), 32'(get_done(which)), 32'd0);
                end
                @(negedge clk);
            end
        end
        chk($sformatf("done_pulse%0d d=%0h", which, data), 32'(get_done(which)), 32'd1);
        chk($sformatf("ready_end%0d d=%0h", which, data), 32'(get_ready(which)), 32'd1);
        chk($sformatf("tx_end%0d d=%0h", which, data), 32'(get_tx(which)), 32'd1);
    endtask

    initial begin
        int lat;

        // Reset state
        rst = 1'b1;
        #7;
        chk("rst_tx1", 32'(tx1), 32'd1);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_tx2", 32'(tx2), 32'd1);
        chk("rst_ready2", 32'(ready2), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xA5
        send(0, 8'hA5, 1'b0);
        wait_start(0, lat);
        chk("lat_a5_range", 32'(lat >= 1 && lat <= 16), 32'd1);
        check_frame(0, 8'hA5);
        @(negedge clk);
        chk("done_single_a5", 32'(done1), 32'd0);
        chk("busy_idle_a5", 32'(busy1), 32'd0);

        // Tick coincident with handshake: ignored, start falls at next tick + 1
        do @(posedge clk); while (!baud_tick);
        repeat (16) @(negedge clk);
        send(0, 8'h3C, 1'b0);
        wait_start(0, lat);
        chk("lat_coincident", 32'(lat), 32'd16);
        check_frame(0, 8'h3C);
        @(negedge clk);
        chk("done_single_3c", 32'(done1), 32'd0);

        // Back-to-back 0x00 then 0xFF with tx_valid held high
        send(0, 8'h00, 1'b1);
        data1 = 8'hFF;
        wait_start(0, lat);
        chk("lat_b2b_first", 32'(lat >= 1 && lat <= 16), 32'd1);
        check_frame(0, 8'h00);
        @(negedge clk);
        chk("b2b_accept_ready", 32'(ready1), 32'd0);
        chk("b2b_accept_busy", 32'(busy1), 32'd1);
        chk("b2b_done_single", 32'(done1), 32'd0);
        valid1 = 1'b0;
        wait_start(0, lat);
        chk("lat_b2b_second", 32'(lat), 32'd15);
        check_frame(0, 8'hFF);
        @(negedge clk);

        // Parity-sensitive byte (plain 8N1 frame when parity is not compiled in)
        send(0, 8'h07, 1'b0);
        wait_start(0, lat);
        check_frame(0, 8'h07);
        @(negedge clk);

        // Narrow instance: 5 data bits, 2 stop bits
        send(1, 8'h1F, 1'b0);
        wait_start(1, lat);
        chk("lat_w5_range", 32'(lat >= 1 && lat <= 16), 32'd1);
        check_frame(1, 8'h1F);
        chk("busy_w5_end", 32'(busy2), 32'd0);
        @(negedge clk);
        chk("done_w5_single", 32'(done2), 32'd0);

        // Reset in the middle of a frame
        send(0, 8'h00, 1'b0);
        wait_start(0, lat);
        repeat (40) @(negedge clk);
        chk("midframe_tx_low", 32'(tx1), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx1), 32'd1);
        chk("midrst_ready", 32'(ready1), 32'd1);
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_done", 32'(done1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_tx", 32'(tx1), 32'd1);
        send(0, 8'h5A, 1'b0);
        wait_start(0, lat);
        chk("lat_postrst_range", 32'(lat >= 1 && lat <= 16), 32'd1);
        check_frame(0, 8'h5A);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
